// File: rtl/regfile_wr_dump_if.sv
// Decode-stage register file bus: write-back, two read ports, debug read and dump stream.
interface regfile_wr_dump_if #(
  parameter int unsigned NB   = 32,
  parameter int unsigned REGS = 5
);
  logic            i_step;
  logic            i_we;
  logic [REGS-1:0] i_dir_wr;
  logic [NB-1:0]   i_data_wr;
  logic [REGS-1:0] i_dir_rs;
  logic [REGS-1:0] i_dir_rt;
  logic [NB-1:0]   o_data_rs;
  logic [NB-1:0]   o_data_rt;
  logic [REGS-1:0] i_reg_debug;
  logic [NB-1:0]   o_reg_debug;
  logic            i_dump_start;
  logic            i_dump_ready;
  logic            o_dump_valid;
  logic [NB-1:0]   o_dump_data;
  logic [REGS-1:0] o_dump_idx;
  logic            o_dump_busy;
  logic            o_dump_done;

  modport master (
    output i_step, i_we, i_dir_wr, i_data_wr, i_dir_rs, i_dir_rt, i_reg_debug,
           i_dump_start, i_dump_ready,
    input  o_data_rs, o_data_rt, o_reg_debug, o_dump_valid, o_dump_data, o_dump_idx,
           o_dump_busy, o_dump_done
  );

  modport slave (
    input  i_step, i_we, i_dir_wr, i_data_wr, i_dir_rs, i_dir_rt, i_reg_debug,
           i_dump_start, i_dump_ready,
    output o_data_rs, o_data_rt, o_reg_debug, o_dump_valid, o_dump_data, o_dump_idx,
           o_dump_busy, o_dump_done
  );
endinterface

// File: rtl/regfile_wr_dump.sv
// MIPS register file with gated write-back, write->read bypass, debug read port and a
// handshaked sequencer that streams every register out to the debug unit.
module regfile_wr_dump #(
  parameter int unsigned NB         = 32,
  parameter int unsigned REGS       = 5,
  parameter int unsigned TAM        = 32,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          RESET_INIT = 1'b0
) (
  input logic              i_clk,
  input logic              i_reset,
  regfile_wr_dump_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

  localparam logic [REGS-1:0] LastIdx = REGS'(TAM - 1);

  function automatic logic in_range(input logic [REGS-1:0] addr);
    return 32'(addr) < TAM;
  endfunction

  function automatic logic is_zero(input logic [REGS-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  function automatic logic [NB-1:0] init_val(input int unsigned i);
    return RESET_INIT ? NB'(i) : '0;
  endfunction

  logic [NB-1:0]   regs_q [TAM];
  logic            wr_ok;
  logic [NB-1:0]   rd_rs, rd_rt, rd_dbg;

  dump_state_e     state_q, state_d;
  logic [REGS-1:0] idx_q, idx_d;
  logic [NB-1:0]   data_q, data_d;
  logic [REGS-1:0] nxt_idx;
  logic [NB-1:0]   nxt_word;

  assign wr_ok = bus.i_step & bus.i_we & in_range(bus.i_dir_wr) & ~is_zero(bus.i_dir_wr);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < TAM; i++) begin
        regs_q[i] <= init_val(i);
      end
    end else if (wr_ok) begin
      regs_q[bus.i_dir_wr] <= bus.i_data_wr;
    end
  end

  // Read ports see this cycle's write-back; the debug port shows only stored state.
  always_comb begin
    rd_rs = '0;
    if (in_range(bus.i_dir_rs) && !is_zero(bus.i_dir_rs)) begin
      rd_rs = (wr_ok && bus.i_dir_rs == bus.i_dir_wr) ? bus.i_data_wr : regs_q[bus.i_dir_rs];
    end
  end

  always_comb begin
    rd_rt = '0;
    if (in_range(bus.i_dir_rt) && !is_zero(bus.i_dir_rt)) begin
      rd_rt = (wr_ok && bus.i_dir_rt == bus.i_dir_wr) ? bus.i_data_wr : regs_q[bus.i_dir_rt];
    end
  end

  always_comb begin
    rd_dbg = '0;
    if (in_range(bus.i_reg_debug) && !is_zero(bus.i_reg_debug)) begin
      rd_dbg = regs_q[bus.i_reg_debug];
    end
  end

  assign bus.o_data_rs   = rd_rs;
  assign bus.o_data_rt   = rd_rt;
  assign bus.o_reg_debug = rd_dbg;

  // Word the sequencer would load next, taken from pre-write stored state.
  always_comb begin
    nxt_idx  = (state_q == StIdle) ? '0 : idx_q + REGS'(1);
    nxt_word = '0;
    if (in_range(nxt_idx) && !is_zero(nxt_idx)) begin
      nxt_word = regs_q[nxt_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_dump_start) begin
          state_d = StSend;
          idx_d   = nxt_idx;
          data_d  = nxt_word;
        end
      end
      StSend: begin
        if (bus.i_dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d  = nxt_idx;
            data_d = nxt_word;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_dump_valid = (state_q == StSend);
  assign bus.o_dump_busy  = (state_q != StIdle);
  assign bus.o_dump_done  = (state_q == StDone);
  assign bus.o_dump_data  = data_q;
  assign bus.o_dump_idx   = idx_q;

endmodule

// File: tb/tb_regfile_wr_dump.sv
// Bench for regfile_wr_dump: instance A (32 regs, hardwired r0, reg i resets to i) and
// instance B (24 regs, ordinary r0, zero reset) against an array-based reference model.
module tb_regfile_wr_dump;
  localparam int unsigned NB    = 32;
  localparam int unsigned REGS  = 5;
  localparam int unsigned TAM_A = 32;
  localparam int unsigned TAM_B = 24;

  logic clk = 1'b0;
  logic rst;
  logic step, we, start, ready;
  logic [4:0] dir_wr, rs, rt, dbg;
  logic [31:0] data_wr;

  always #5 clk = ~clk;

  regfile_wr_dump_if #(.NB(NB), .REGS(REGS)) ifa ();
  regfile_wr_dump_if #(.NB(NB), .REGS(REGS)) ifb ();

  assign ifa.i_step       = step;
  assign ifa.i_we         = we;
  assign ifa.i_dir_wr     = dir_wr;
  assign ifa.i_data_wr    = data_wr;
  assign ifa.i_dir_rs     = rs;
  assign ifa.i_dir_rt     = rt;
  assign ifa.i_reg_debug  = dbg;
  assign ifa.i_dump_start = start;
  assign ifa.i_dump_ready = ready;

  assign ifb.i_step       = step;
  assign ifb.i_we         = we;
  assign ifb.i_dir_wr     = dir_wr;
  assign ifb.i_data_wr    = data_wr;
  assign ifb.i_dir_rs     = rs;
  assign ifb.i_dir_rt     = rt;
  assign ifb.i_reg_debug  = dbg;
  assign ifb.i_dump_start = 1'b0;
  assign ifb.i_dump_ready = 1'b0;

  regfile_wr_dump #(
    .NB(NB), .REGS(REGS), .TAM(TAM_A), .ZERO_REG(1'b1), .RESET_INIT(1'b1)
  ) dut_a (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (ifa)
  );

  regfile_wr_dump #(
    .NB(NB), .REGS(REGS), .TAM(TAM_B), .ZERO_REG(1'b0), .RESET_INIT(1'b0)
  ) dut_b (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (ifb)
  );

  // Reference model
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          d_act, d_done;
  int          d_idx;
  logic [31:0] d_data;
  int          total = 0;
  int          bad = 0;

  function automatic bit m_wr_ok(input bit zr, input int tam);
    return step && we && (int'(dir_wr) < tam) && !(zr && dir_wr == 5'd0);
  endfunction

  function automatic logic [31:0] m_stored_a(input int a);
    return (a == 0) ? 32'd0 : ma[a];
  endfunction

  function automatic logic [31:0] m_read_a(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && m_wr_ok(1'b1, TAM_A) && a == dir_wr) return data_wr;
    return ma[a];
  endfunction

  function automatic logic [31:0] m_read_b(input logic [4:0] a, input bit byp);
    if (int'(a) >= TAM_B) return 32'd0;
    if (byp && m_wr_ok(1'b0, TAM_B) && a == dir_wr) return data_wr;
    return mb[a];
  endfunction

  task automatic model_edge();
    bit was_done;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = i;
        mb[i] = 32'd0;
      end
      d_act  = 1'b0;
      d_done = 1'b0;
    end else begin
      was_done = d_done;
      d_done   = 1'b0;
      if (d_act && ready) begin
        if (d_idx == TAM_A - 1) begin
          d_act  = 1'b0;
          d_done = 1'b1;
        end else begin
          d_idx  = d_idx + 1;
          d_data = m_stored_a(d_idx);
        end
      end else if (!d_act && !was_done && start) begin
        d_act  = 1'b1;
        d_idx  = 0;
        d_data = m_stored_a(0);
      end
      if (m_wr_ok(1'b1, TAM_A)) ma[dir_wr] = data_wr;
      if (m_wr_ok(1'b0, TAM_B)) mb[dir_wr] = data_wr;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("a_rs", ifa.o_data_rs, m_read_a(rs, 1'b1));
    chk("a_rt", ifa.o_data_rt, m_read_a(rt, 1'b1));
    chk("a_dbg", ifa.o_reg_debug, m_read_a(dbg, 1'b0));
    chk("b_rs", ifb.o_data_rs, m_read_b(rs, 1'b1));
    chk("b_rt", ifb.o_data_rt, m_read_b(rt, 1'b1));
    chk("b_dbg", ifb.o_reg_debug, m_read_b(dbg, 1'b0));
    chk("a_valid", 32'(ifa.o_dump_valid), 32'(d_act));
    chk("a_busy", 32'(ifa.o_dump_busy), 32'(d_act || d_done));
    chk("a_done", 32'(ifa.o_dump_done), 32'(d_done));
    chk("b_busy", 32'(ifb.o_dump_busy), 32'd0);
    if (d_act) begin
      chk("a_idx", 32'(ifa.o_dump_idx), d_idx);
      chk("a_data", ifa.o_dump_data, d_data);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    #2;
    check_model();
    tick();
  endtask

  task automatic quiet();
    step = 1'b0; we = 1'b0; dir_wr = 5'd0; data_wr = 32'd0;
    start = 1'b0; ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          step;
    bit          we;
    logic [4:0]  wr;
    logic [31:0] data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] ers;
    logic [31:0] ert;
    logic [31:0] edbg;
  } vec_t;

  vec_t tbl [9];
  int   k;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 5'd0,  32'd7,        32'd31,       32'd0};
    tbl[1] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  5'd5,  32'hDEADBEEF, 32'd6,        32'd5};
    tbl[2] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 5'd6,  32'h12345678, 5'd6,  5'd6,  5'd6,  32'd6,        32'd6,        32'd6};
    tbl[4] = '{1'b1, 1'b0, 5'd6,  32'h1,        5'd6,  5'd5,  5'd6,  32'd6,        32'hDEADBEEF, 32'd6};
    tbl[5] = '{1'b1, 1'b1, 5'd0,  32'h1234,     5'd0,  5'd0,  5'd0,  32'd0,        32'd0,        32'd0};
    tbl[6] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  5'd0,  32'd0,        32'd7,        32'd0};
    tbl[7] = '{1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 5'd31, 32'hCAFEF00D, 32'd30,       32'd31};
    tbl[8] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};

    quiet();
    rs = 5'd0; rt = 5'd0; dbg = 5'd0;
    do_reset();
    #2;
    chk("rst_valid", 32'(ifa.o_dump_valid), 32'd0);
    chk("rst_busy", 32'(ifa.o_dump_busy), 32'd0);
    chk("rst_done", 32'(ifa.o_dump_done), 32'd0);
    chk("rst_idx", 32'(ifa.o_dump_idx), 32'd0);
    chk("rst_data", ifa.o_dump_data, 32'd0);

    // Directed read/write/bypass vectors on instance A.
    for (int i = 0; i < 9; i++) begin
      step = tbl[i].step; we = tbl[i].we; dir_wr = tbl[i].wr; data_wr = tbl[i].data;
      rs = tbl[i].rs; rt = tbl[i].rt; dbg = tbl[i].dbg;
      #2;
      chk($sformatf("vec%0d_rs", i), ifa.o_data_rs, tbl[i].ers);
      chk($sformatf("vec%0d_rt", i), ifa.o_data_rt, tbl[i].ert);
      chk($sformatf("vec%0d_dbg", i), ifa.o_reg_debug, tbl[i].edbg);
      check_model();
      tick();
    end

    // Instance B: r0 is ordinary, addresses >= 24 drop writes and read 0.
    quiet();
    rs = 5'd0; rt = 5'd25; dbg = 5'd0;
    #2;
    chk("b_r0_rs", ifb.o_data_rs, 32'h1234);
    chk("b_r0_dbg", ifb.o_reg_debug, 32'h1234);
    tick();
    step = 1'b1; we = 1'b1; dir_wr = 5'd25; data_wr = 32'h55;
    #2;
    chk("b_oob_bypass", ifb.o_data_rt, 32'd0);
    tick();
    quiet();
    #2;
    chk("b_oob_read", ifb.o_data_rt, 32'd0);
    tick();

    // Full dump with ready held high.
    do_reset();
    start = 1'b1; ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #2;
      chk("d1_valid", 32'(ifa.o_dump_valid), 32'd1);
      chk("d1_idx", 32'(ifa.o_dump_idx), i);
      chk("d1_data", ifa.o_dump_data, i);
      check_model();
      tick();
    end
    #2;
    chk("d1_done", 32'(ifa.o_dump_done), 32'd1);
    chk("d1_valid_end", 32'(ifa.o_dump_valid), 32'd0);
    chk("d1_busy_done", 32'(ifa.o_dump_busy), 32'd1);
    tick();
    #2;
    chk("d1_done_pulse", 32'(ifa.o_dump_done), 32'd0);
    chk("d1_busy_end", 32'(ifa.o_dump_busy), 32'd0);
    tick();

    // Stalling dump; the presented register is overwritten during the stall.
    do_reset();
    start = 1'b1; ready = 1'b0;
    cyc();
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 200 && k < 32; c++) begin
      ready = (c % 3 == 0);
      if (c % 3 == 1) begin
        step = 1'b1; we = 1'b1; dir_wr = 5'(k); data_wr = 32'hAA;
      end else begin
        step = 1'b0; we = 1'b0;
      end
      #2;
      chk("d2_valid", 32'(ifa.o_dump_valid), 32'd1);
      chk("d2_idx", 32'(ifa.o_dump_idx), k);
      chk("d2_data", ifa.o_dump_data, k);
      check_model();
      tick();
      if (ready) k++;
    end
    chk("d2_count", k, 32'd32);
    quiet();
    #2;
    chk("d2_done", 32'(ifa.o_dump_done), 32'd1);
    tick();

    // Reset in the middle of a dump, then restart.
    do_reset();
    start = 1'b1; ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    #2;
    chk("d3_idx10", 32'(ifa.o_dump_idx), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b0;
    #2;
    chk("d3_valid", 32'(ifa.o_dump_valid), 32'd0);
    chk("d3_busy", 32'(ifa.o_dump_busy), 32'd0);
    chk("d3_idx", 32'(ifa.o_dump_idx), 32'd0);
    chk("d3_data", ifa.o_dump_data, 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    #2;
    chk("d3_restart_valid", 32'(ifa.o_dump_valid), 32'd1);
    chk("d3_restart_idx", 32'(ifa.o_dump_idx), 32'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step    = ($urandom_range(0, 3) != 0);
      we      = ($urandom_range(0, 3) != 0);
      dir_wr  = 5'($urandom_range(0, 31));
      data_wr = $urandom;
      rs      = ($urandom_range(0, 2) == 0) ? dir_wr : 5'($urandom_range(0, 31));
      rt      = ($urandom_range(0, 2) == 0) ? dir_wr : 5'($urandom_range(0, 31));
      dbg     = ($urandom_range(0, 2) == 0) ? dir_wr : 5'($urandom_range(0, 31));
      start   = ($urandom_range(0, 7) == 0);
      ready   = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0;
    quiet();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
